// File: rtl/fwd_store_buffer.sv
// fwd_store_buffer: FIFO store buffer for the data-memory stage.
// Stores queue in order and drain to the D-cache over valid/ready; loads
// see same-cycle forwarding from the youngest matching entry, and a
// partial overlap raises a conflict so the load stalls until it drains.
module fwd_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_store_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  input  logic [2:0]        in_funct3,
  input  logic              in_load_valid,
  input  logic [ADDR_W-1:0] in_load_addr,
  input  logic [2:0]        in_load_funct3,
  input  logic              in_drain_ready,
  output logic              out_drain_valid,
  output logic [ADDR_W-1:0] out_drain_addr,
  output logic [31:0]       out_drain_data,
  output logic [3:0]        out_drain_mask,
  output logic              out_fwd_hit,
  output logic [31:0]       out_fwd_data,
  output logic              out_fwd_conflict,
  output logic              out_stall,
  output logic              out_misaligned,
  output logic              out_full,
  output logic              out_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int WA_W  = ADDR_W - 2;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  // Memory access size / signedness codes (funct3)
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_op_e;

  // Entry storage; contents are only meaningful for slots inside [rd_ptr, rd_ptr+count)
  logic [WA_W-1:0]  ent_waddr [DEPTH];
  logic [3:0]       ent_mask  [DEPTH];
  logic [31:0]      ent_data  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // Store decode
  logic             st_legal;
  logic             st_mis;
  logic [3:0]       st_mask;
  logic [31:0]      st_lanes;

  // Load decode
  logic             ld_legal;
  logic             ld_mis;
  logic [3:0]       ld_mask;

  // Forwarding search results
  logic             any_match;
  logic [3:0]       y_mask;
  logic [31:0]      y_data;
  logic [PTR_W-1:0] idx;
  logic             lookup;
  logic             covered;
  logic [31:0]      ld_sel;
  logic [31:0]      ld_ext;

  logic             enq;
  logic             deq;

  // Status flags derive from the registered count only
  always_comb begin
    out_full        = (count == CNT_FULL);
    out_empty       = (count == '0);
    out_drain_valid = ~out_empty;
    out_stall       = in_store_valid & out_full;
  end

  // Store decode: legality, alignment, byte mask and lane-aligned data
  always_comb begin
    st_legal = 1'b1;
    st_mis   = 1'b0;
    st_mask  = '0;
    st_lanes = '0;
    case (in_funct3)
      MEM_B: begin
        st_mask  = 4'b0001 << in_addr[1:0];
        st_lanes = {24'b0, in_data[7:0]} << {in_addr[1:0], 3'b000};
      end
      MEM_H: begin
        st_mis   = in_addr[0];
        st_mask  = 4'b0011 << {in_addr[1], 1'b0};
        st_lanes = {16'b0, in_data[15:0]} << {in_addr[1], 4'b0000};
      end
      MEM_W: begin
        st_mis   = |in_addr[1:0];
        st_mask  = 4'b1111;
        st_lanes = in_data;
      end
      default: st_legal = 1'b0;
    endcase
  end

  // Load decode: legality, alignment and the byte lanes the load needs
  always_comb begin
    ld_legal = 1'b1;
    ld_mis   = 1'b0;
    ld_mask  = '0;
    case (in_load_funct3)
      MEM_B, MEM_BU: begin
        ld_mask = 4'b0001 << in_load_addr[1:0];
      end
      MEM_H, MEM_HU: begin
        ld_mis  = in_load_addr[0];
        ld_mask = 4'b0011 << {in_load_addr[1], 1'b0};
      end
      MEM_W: begin
        ld_mis  = |in_load_addr[1:0];
        ld_mask = 4'b1111;
      end
      default: ld_legal = 1'b0;
    endcase
  end

  // Handshake qualification and misalignment pulse
  always_comb begin
    enq            = in_store_valid & ~out_full & st_legal & ~st_mis;
    deq            = out_drain_valid & in_drain_ready;
    out_misaligned = (in_store_valid & st_legal & st_mis) |
                     (in_load_valid  & ld_legal & ld_mis);
  end

  // Head entry presented to the cache; zeroed while the buffer is empty
  always_comb begin
    out_drain_addr = '0;
    out_drain_data = '0;
    out_drain_mask = '0;
    if (out_drain_valid) begin
      out_drain_addr = {ent_waddr[rd_ptr], 2'b00};
      out_drain_data = ent_data[rd_ptr];
      out_drain_mask = ent_mask[rd_ptr];
    end
  end

  // Walk live entries oldest to youngest; the last word match wins, which
  // yields the youngest match without a priority encoder on the reversed order
  always_comb begin
    any_match = 1'b0;
    y_mask    = '0;
    y_data    = '0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) &&
          (ent_waddr[idx] == in_load_addr[ADDR_W-1:2])) begin
        any_match = 1'b1;
        y_mask    = ent_mask[idx];
        y_data    = ent_data[idx];
      end
    end
  end

  // Hit/conflict classification and lane extraction with extension
  always_comb begin
    lookup  = in_load_valid & ld_legal & ~ld_mis;
    covered = ((y_mask & ld_mask) == ld_mask);
    ld_sel  = y_data >> {in_load_addr[1:0], 3'b000};
    case (in_load_funct3)
      MEM_B:   ld_ext = {{24{ld_sel[7]}}, ld_sel[7:0]};
      MEM_H:   ld_ext = {{16{ld_sel[15]}}, ld_sel[15:0]};
      MEM_W:   ld_ext = ld_sel;
      MEM_BU:  ld_ext = {24'b0, ld_sel[7:0]};
      MEM_HU:  ld_ext = {16'b0, ld_sel[15:0]};
      default: ld_ext = '0;
    endcase
    out_fwd_hit      = lookup & any_match & covered;
    out_fwd_conflict = lookup & any_match & ~covered;
    out_fwd_data     = out_fwd_hit ? ld_ext : '0;
  end

  // Pointer and occupancy tracking; reset empties the buffer immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry write on enqueue; payload needs no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_waddr[wr_ptr] <= in_addr[ADDR_W-1:2];
      ent_mask[wr_ptr]  <= st_mask;
      ent_data[wr_ptr]  <= st_lanes;
    end
  end

endmodule

// File: tb/tb_fwd_store_buffer.sv
// tb_fwd_store_buffer: directed vector table, hand-written multi-cycle
// sequences and randomized traffic against a byte-level queue model.
module tb_fwd_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  localparam logic [2:0] F_SB  = 3'b000;
  localparam logic [2:0] F_SH  = 3'b001;
  localparam logic [2:0] F_SW  = 3'b010;
  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_store_valid;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_data;
  logic [2:0]        in_funct3;
  logic              in_load_valid;
  logic [ADDR_W-1:0] in_load_addr;
  logic [2:0]        in_load_funct3;
  logic              in_drain_ready;
  logic              out_drain_valid;
  logic [ADDR_W-1:0] out_drain_addr;
  logic [31:0]       out_drain_data;
  logic [3:0]        out_drain_mask;
  logic              out_fwd_hit;
  logic [31:0]       out_fwd_data;
  logic              out_fwd_conflict;
  logic              out_stall;
  logic              out_misaligned;
  logic              out_full;
  logic              out_empty;

  always #5 clk = ~clk;

  fwd_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_store_valid   (in_store_valid),
    .in_addr          (in_addr),
    .in_data          (in_data),
    .in_funct3        (in_funct3),
    .in_load_valid    (in_load_valid),
    .in_load_addr     (in_load_addr),
    .in_load_funct3   (in_load_funct3),
    .in_drain_ready   (in_drain_ready),
    .out_drain_valid  (out_drain_valid),
    .out_drain_addr   (out_drain_addr),
    .out_drain_data   (out_drain_data),
    .out_drain_mask   (out_drain_mask),
    .out_fwd_hit      (out_fwd_hit),
    .out_fwd_data     (out_fwd_data),
    .out_fwd_conflict (out_fwd_conflict),
    .out_stall        (out_stall),
    .out_misaligned   (out_misaligned),
    .out_full         (out_full),
    .out_empty        (out_empty)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic v, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
    in_store_valid = v;
    in_funct3      = f3;
    in_addr        = a;
    in_data        = d;
  endtask

  task automatic set_load(input logic v, input logic [2:0] f3, input logic [31:0] a);
    in_load_valid  = v;
    in_load_funct3 = f3;
    in_load_addr   = a;
  endtask

  // One directed cycle: inputs plus the expected combinational outputs
  typedef struct {
    logic        sv;
    logic [2:0]  sf3;
    logic [31:0] saddr;
    logic [31:0] sdata;
    logic        lv;
    logic [2:0]  lf3;
    logic [31:0] laddr;
    logic        rdy;
    logic        e_hit;
    logic        e_conf;
    logic [31:0] e_fdata;
    logic        e_mis;
    logic        e_empty;
    logic        e_dv;
    logic [31:0] e_daddr;
    logic [31:0] e_ddata;
    logic [3:0]  e_dmask;
  } vec_t;

  function automatic vec_t v(
    input logic sv, input logic [2:0] sf3, input logic [31:0] saddr, input logic [31:0] sdata,
    input logic lv, input logic [2:0] lf3, input logic [31:0] laddr, input logic rdy,
    input logic e_hit, input logic e_conf, input logic [31:0] e_fdata, input logic e_mis,
    input logic e_empty, input logic e_dv, input logic [31:0] e_daddr,
    input logic [31:0] e_ddata, input logic [3:0] e_dmask);
    vec_t r;
    r.sv = sv; r.sf3 = sf3; r.saddr = saddr; r.sdata = sdata;
    r.lv = lv; r.lf3 = lf3; r.laddr = laddr; r.rdy = rdy;
    r.e_hit = e_hit; r.e_conf = e_conf; r.e_fdata = e_fdata; r.e_mis = e_mis;
    r.e_empty = e_empty; r.e_dv = e_dv; r.e_daddr = e_daddr;
    r.e_ddata = e_ddata; r.e_dmask = e_dmask;
    return r;
  endfunction

  vec_t vt[15];

  // Reference model: queue of word entries with byte mask and lane data
  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  mask;
    logic [31:0] data;
  } ment_t;

  ment_t       q[$];
  ment_t       ne;
  logic        m_full, m_empty, st_ok, st_mis, ld_ok, ld_mis, full_cov;
  logic        e_hit, e_conf, e_mis, e_stall, m_enq, m_deq;
  logic [31:0] e_fd, val;
  int          st_sz, ld_sz, found, lane;

  initial begin
    reset = 1'b1;
    set_store(1'b0, F_SW, '0, '0);
    set_load(1'b0, F_LW, '0);
    in_drain_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_dvalid", out_drain_valid, 1'b0);
    chk1("rst_empty", out_empty, 1'b1);
    chk1("rst_full", out_full, 1'b0);
    chk1("rst_hit", out_fwd_hit, 1'b0);
    reset = 1'b0;
    tick();

    // ---------------- directed vector table ----------------
    vt[0]  = v(1'b1, F_SW, 32'h100, 32'hDEADBEEF, 1'b0, F_LW, '0, 1'b0,
               1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 4'h0);
    vt[1]  = v(1'b0, F_SW, '0, '0, 1'b1, F_LW, 32'h100, 1'b0,
               1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    vt[2]  = v(1'b0, F_SW, '0, '0, 1'b0, F_LW, '0, 1'b1,
               1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    vt[3]  = v(1'b1, F_SB, 32'h101, 32'h80, 1'b0, F_LW, '0, 1'b0,
               1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 4'h0);
    vt[4]  = v(1'b0, F_SB, '0, '0, 1'b1, F_LB, 32'h101, 1'b0,
               1'b1, 1'b0, 32'hFFFFFF80, 1'b0, 1'b0, 1'b1, 32'h100, 32'h00008000, 4'h2);
    vt[5]  = v(1'b0, F_SB, '0, '0, 1'b1, F_LBU, 32'h101, 1'b0,
               1'b1, 1'b0, 32'h00000080, 1'b0, 1'b0, 1'b1, 32'h100, 32'h00008000, 4'h2);
    vt[6]  = v(1'b0, F_SB, '0, '0, 1'b1, F_LW, 32'h100, 1'b0,
               1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h00008000, 4'h2);
    vt[7]  = v(1'b0, F_SB, '0, '0, 1'b0, F_LW, '0, 1'b1,
               1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h00008000, 4'h2);
    vt[8]  = v(1'b1, F_SW, 32'h200, 32'h11111111, 1'b0, F_LW, '0, 1'b0,
               1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 4'h0);
    vt[9]  = v(1'b1, F_SW, 32'h200, 32'h22222222, 1'b0, F_LW, '0, 1'b0,
               1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h11111111, 4'hF);
    vt[10] = v(1'b0, F_SW, '0, '0, 1'b1, F_LW, 32'h200, 1'b1,
               1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0, 1'b1, 32'h200, 32'h11111111, 4'hF);
    vt[11] = v(1'b0, F_SW, '0, '0, 1'b0, F_LW, '0, 1'b1,
               1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h22222222, 4'hF);
    vt[12] = v(1'b0, F_SW, '0, '0, 1'b0, F_LW, '0, 1'b0,
               1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 4'h0);
    vt[13] = v(1'b1, F_SH, 32'h103, 32'h1234, 1'b0, F_LW, '0, 1'b0,
               1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0, '0, 4'h0);
    vt[14] = v(1'b0, F_SW, '0, '0, 1'b1, F_LW, 32'h102, 1'b0,
               1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0, '0, 4'h0);

    for (int i = 0; i < 15; i++) begin
      set_store(vt[i].sv, vt[i].sf3, vt[i].saddr, vt[i].sdata);
      set_load(vt[i].lv, vt[i].lf3, vt[i].laddr);
      in_drain_ready = vt[i].rdy;
      @(negedge clk);
      chk1($sformatf("vec%0d_hit", i), out_fwd_hit, vt[i].e_hit);
      chk1($sformatf("vec%0d_conflict", i), out_fwd_conflict, vt[i].e_conf);
      chk($sformatf("vec%0d_fwd_data", i), out_fwd_data, vt[i].e_fdata);
      chk1($sformatf("vec%0d_misaligned", i), out_misaligned, vt[i].e_mis);
      chk1($sformatf("vec%0d_empty", i), out_empty, vt[i].e_empty);
      chk1($sformatf("vec%0d_dvalid", i), out_drain_valid, vt[i].e_dv);
      if (vt[i].e_dv) begin
        chk($sformatf("vec%0d_daddr", i), out_drain_addr, vt[i].e_daddr);
        chk($sformatf("vec%0d_ddata", i), out_drain_data, vt[i].e_ddata);
        chk($sformatf("vec%0d_dmask", i), 32'(out_drain_mask), 32'(vt[i].e_dmask));
      end
      tick();
    end

    // ---------------- fill, stall, drain, wrap ----------------
    set_load(1'b0, F_LW, '0);
    in_drain_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_store(1'b1, F_SW, 32'h300 + 4 * k, 32'hA0000000 + k);
      tick();
    end
    set_store(1'b0, F_SW, '0, '0);
    #1;
    chk1("fill_full", out_full, 1'b1);
    chk1("fill_not_stalled_idle", out_stall, 1'b0);
    set_store(1'b1, F_SW, 32'h310, 32'h0BAD0BAD);
    #1;
    chk1("full_stall", out_stall, 1'b1);
    tick();
    chk1("stall_keeps_full", out_full, 1'b1);
    chk("stall_head", out_drain_data, 32'hA0000000);
    in_drain_ready = 1'b1;
    #1;
    chk1("stall_ignores_ready", out_stall, 1'b1);
    tick();
    set_store(1'b0, F_SW, '0, '0);
    #1;
    chk1("after_drain_not_full", out_full, 1'b0);
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("drain%0d_data", k), out_drain_data, 32'hA0000000 + k);
      chk($sformatf("drain%0d_addr", k), out_drain_addr, 32'h300 + 4 * k);
      tick();
    end
    #1;
    chk1("stalled_store_dropped", out_empty, 1'b1);

    in_drain_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_store(1'b1, F_SW, 32'h320 + 4 * k, 32'hB0 + k);
      tick();
    end
    set_store(1'b0, F_SW, '0, '0);
    in_drain_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("pre_wrap%0d", k), out_drain_data, 32'hB0 + k);
      tick();
    end
    in_drain_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_store(1'b1, F_SW, 32'h340 + 4 * k, 32'hC0000000 + k);
      tick();
    end
    set_store(1'b0, F_SW, '0, '0);
    in_drain_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("wrap%0d_data", k), out_drain_data, 32'hC0000000 + k);
      tick();
    end
    #1;
    chk1("wrap_empty", out_empty, 1'b1);

    // ---------------- reset while draining ----------------
    in_drain_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_store(1'b1, F_SW, 32'h400 + 4 * k, 32'hD0 + k);
      tick();
    end
    set_store(1'b1, F_SW, 32'h500, 32'h55);
    set_load(1'b1, F_LW, 32'h400);
    in_drain_ready = 1'b1;
    #1;
    chk1("pre_reset_dvalid", out_drain_valid, 1'b1);
    chk1("pre_reset_hit", out_fwd_hit, 1'b1);
    reset = 1'b1;
    #1;
    chk1("async_rst_dvalid", out_drain_valid, 1'b0);
    chk1("async_rst_empty", out_empty, 1'b1);
    chk1("async_rst_full", out_full, 1'b0);
    chk1("async_rst_stall", out_stall, 1'b0);
    chk1("async_rst_hit", out_fwd_hit, 1'b0);
    chk1("async_rst_conflict", out_fwd_conflict, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    set_store(1'b0, F_SW, '0, '0);
    in_drain_ready = 1'b0;
    #1;
    chk1("post_rst_hit", out_fwd_hit, 1'b0);
    chk1("post_rst_conflict", out_fwd_conflict, 1'b0);
    tick();
    set_load(1'b0, F_LW, '0);
    #1;
    chk1("random_start_empty", out_empty, 1'b1);

    // ---------------- randomized traffic vs. queue model ----------------
    q.delete();
    for (int n = 0; n < 1500; n++) begin
      in_store_valid = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 4))
        0: in_funct3 = 3'b000;
        1: in_funct3 = 3'b001;
        2, 3: in_funct3 = 3'b010;
        default: in_funct3 = 3'b011;
      endcase
      in_addr       = 32'h500 + $urandom_range(0, 15);
      in_data       = $urandom;
      in_load_valid = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 6))
        0: in_load_funct3 = 3'b000;
        1: in_load_funct3 = 3'b001;
        2: in_load_funct3 = 3'b010;
        3: in_load_funct3 = 3'b100;
        4: in_load_funct3 = 3'b101;
        5: in_load_funct3 = 3'b010;
        default: in_load_funct3 = 3'b110;
      endcase
      in_load_addr   = 32'h500 + $urandom_range(0, 15);
      in_drain_ready = ($urandom_range(0, 9) < 4);
      @(negedge clk);

      m_full  = (q.size() == DEPTH);
      m_empty = (q.size() == 0);
      st_ok   = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
      st_sz   = 1 << in_funct3[1:0];
      st_mis  = st_ok && ((in_addr % st_sz) != 0);
      ld_ok   = in_load_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      ld_sz   = 1 << in_load_funct3[1:0];
      ld_mis  = ld_ok && ((in_load_addr % ld_sz) != 0);
      e_hit   = 1'b0;
      e_conf  = 1'b0;
      e_fd    = '0;
      if (in_load_valid && ld_ok && !ld_mis) begin
        found = -1;
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].waddr == in_load_addr[31:2]) begin
            found = i;
            break;
          end
        end
        if (found >= 0) begin
          full_cov = 1'b1;
          val      = '0;
          for (int k = 0; k < ld_sz; k++) begin
            lane = int'(in_load_addr[1:0]) + k;
            if (!q[found].mask[lane]) full_cov = 1'b0;
            val[8*k +: 8] = q[found].data[8*lane +: 8];
          end
          if (full_cov) begin
            e_hit = 1'b1;
            if (!in_load_funct3[2] && ld_sz == 1) val = {{24{val[7]}}, val[7:0]};
            if (!in_load_funct3[2] && ld_sz == 2) val = {{16{val[15]}}, val[15:0]};
            e_fd = val;
          end else begin
            e_conf = 1'b1;
          end
        end
      end
      e_mis   = (in_store_valid && st_mis) || (in_load_valid && ld_mis);
      e_stall = in_store_valid && m_full;

      chk1("rnd_hit", out_fwd_hit, e_hit);
      chk1("rnd_conflict", out_fwd_conflict, e_conf);
      chk("rnd_fwd_data", out_fwd_data, e_fd);
      chk1("rnd_misaligned", out_misaligned, e_mis);
      chk1("rnd_stall", out_stall, e_stall);
      chk1("rnd_full", out_full, m_full);
      chk1("rnd_empty", out_empty, m_empty);
      chk1("rnd_dvalid", out_drain_valid, !m_empty);
      if (!m_empty) begin
        chk("rnd_daddr", out_drain_addr, {q[0].waddr, 2'b00});
        chk("rnd_ddata", out_drain_data, q[0].data);
        chk("rnd_dmask", 32'(out_drain_mask), 32'(q[0].mask));
      end

      m_enq = in_store_valid && st_ok && !st_mis && !m_full;
      m_deq = !m_empty && in_drain_ready;
      ne    = '0;
      ne.waddr = in_addr[31:2];
      for (int k = 0; k < st_sz; k++) begin
        lane = int'(in_addr[1:0]) + k;
        ne.mask[lane] = 1'b1;
        ne.data[8*lane +: 8] = in_data[8*k +: 8];
      end
      tick();
      if (m_deq) void'(q.pop_front());
      if (m_enq) q.push_back(ne);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
